// File: rtl/sad_pkg.sv
`default_nettype none
// ============================================================================
// Module     : sad_pkg
// Purpose    : Shared definitions for the SAD absolute-difference accumulator:
//              default pixel width and block size, result-width derivation,
//              and the accumulator FSM state encoding.
// Ports      : none (package)
// Revision   : 1.0 - initial release
// ============================================================================
package sad_pkg;

  localparam int PIX_W_DEFAULT = 8;
  localparam int BLK_N_DEFAULT = 16;

  // Result width that can hold BLK_N * (2^PIX_W - 1) without overflow.
  function automatic int sad_width(input int pix_w, input int blk_n);
    return pix_w + $clog2(blk_n);
  endfunction

  typedef enum logic [1:0] {
    ST_ACCUM = 2'd0,
    ST_DRAIN = 2'd1,
    ST_HOLD  = 2'd2
  } sad_state_t;

endpackage
`default_nettype wire

// File: rtl/abs_diff.sv
`default_nettype none
// ============================================================================
// Module     : abs_diff
// Purpose    : Combinational |a - b| for unsigned pixels. A ripple chain of
//              one-bit adder cells forms a + ~b + 1; a clear carry-out means
//              a < b, in which case the raw result is negated (invert, +1).
// Ports      : a    - input  [PIX_W-1:0] minuend pixel
//              b    - input  [PIX_W-1:0] subtrahend pixel
//              diff - output [PIX_W-1:0] absolute difference
// Revision   : 1.0 - initial release
// ============================================================================
module abs_diff
  import sad_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEFAULT
) (
  input  logic [PIX_W-1:0] a,
  input  logic [PIX_W-1:0] b,
  output logic [PIX_W-1:0] diff
);

  logic [PIX_W:0]   carry;
  logic [PIX_W-1:0] b_n;
  logic [PIX_W-1:0] raw;
  logic             neg;

  assign b_n      = ~b;
  assign carry[0] = 1'b1;  // the +1 of two's-complement subtraction

  for (genvar i = 0; i < PIX_W; i++) begin : g_ripple
    assign raw[i]       = a[i] ^ b_n[i] ^ carry[i];
    assign carry[i+1]   = (a[i] & b_n[i]) | (carry[i] & (a[i] ^ b_n[i]));
  end

  // Extending to PIX_W+1 bits would put 0 + 1 + carry in the top cell, whose
  // carry-out equals carry[PIX_W]; so the PIX_W-bit chain's carry is the sign.
  assign neg  = ~carry[PIX_W];
  assign diff = (raw ^ {PIX_W{neg}}) + {{(PIX_W-1){1'b0}}, neg};

endmodule
`default_nettype wire

// File: rtl/sad_abs_diff_accum.sv
`default_nettype none
// ============================================================================
// Module     : sad_abs_diff_accum
// Purpose    : Pipelined SAD block accumulator. Takes one pixel pair per
//              accepted cycle, registers |a-b|, sums BLK_N differences and
//              presents the block total on a valid/ready output.
// Ports      : i_clk        - input         clock, rising edge
//              i_rst        - input         synchronous active-high reset
//              i_valid      - input         pixel pair present
//              i_a, i_b     - input  [PIX_W] current / reference pixel
//              o_ready      - output        pair accepted this cycle if valid
//              o_sad        - output [SAD_W] completed block SAD
//              o_sad_valid  - output        o_sad holds a result
//              i_sad_ready  - input         consumer takes o_sad
// Revision   : 1.0 - initial release
// ============================================================================
module sad_abs_diff_accum
  import sad_pkg::*;
#(
  parameter int PIX_W = PIX_W_DEFAULT,
  parameter int BLK_N = BLK_N_DEFAULT,
  parameter int SAD_W = sad_width(PIX_W, BLK_N)
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_valid,
  input  logic [PIX_W-1:0] i_a,
  input  logic [PIX_W-1:0] i_b,
  output logic             o_ready,
  output logic [SAD_W-1:0] o_sad,
  output logic             o_sad_valid,
  input  logic             i_sad_ready
);

  localparam int             CNT_W    = $clog2(BLK_N);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLK_N - 1);

  sad_state_t       state;
  sad_state_t       state_next;
  logic [CNT_W-1:0] cnt;
  logic [PIX_W-1:0] diff_comb;
  logic [PIX_W-1:0] d;
  logic             d_vld;
  logic             d_first;
  logic [SAD_W-1:0] acc;
  logic             accept;
  logic             load_sad;
  logic             clr_sad;

  abs_diff #(
    .PIX_W (PIX_W)
  ) u_abs_diff (
    .a    (i_a),
    .b    (i_b),
    .diff (diff_comb)
  );

  // Decoded from registered state and reset only.
  assign o_ready = (state == ST_ACCUM) && !i_rst;
  assign accept  = i_valid && o_ready;

  // --------------------------------------------------------------------------
  // FSM
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state <= ST_ACCUM;
    end else begin
      state <= state_next;
    end
  end

  always_comb begin
    state_next = state;
    load_sad   = 1'b0;
    clr_sad    = 1'b0;
    case (state)
      ST_ACCUM: begin
        if (accept && (cnt == CNT_LAST)) begin
          state_next = ST_DRAIN;
        end
      end
      ST_DRAIN: begin
        // Wait for the last difference to land in acc before publishing.
        if (!d_vld) begin
          load_sad   = 1'b1;
          state_next = ST_HOLD;
        end
      end
      ST_HOLD: begin
        if (i_sad_ready) begin
          clr_sad    = 1'b1;
          state_next = ST_ACCUM;
        end
      end
      default: begin
        state_next = ST_ACCUM;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Datapath: difference register, counter, accumulator, result register
  // --------------------------------------------------------------------------
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cnt     <= '0;
      d       <= '0;
      d_vld   <= 1'b0;
      d_first <= 1'b0;
      acc     <= '0;
    end else begin
      d_vld <= accept;
      if (accept) begin
        d       <= diff_comb;
        // cnt wraps naturally after the BLK_N-th accept (BLK_N is a power of
        // two), so cnt==0 tags the first pair of a block.
        d_first <= (cnt == '0);
        cnt     <= cnt + 1'b1;
      end
      if (d_vld) begin
        acc <= (d_first ? '0 : acc) + {{(SAD_W-PIX_W){1'b0}}, d};
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      o_sad       <= '0;
      o_sad_valid <= 1'b0;
    end else if (load_sad) begin
      o_sad       <= acc;
      o_sad_valid <= 1'b1;
    end else if (clr_sad) begin
      o_sad_valid <= 1'b0;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_sad_abs_diff_accum.sv
`default_nettype none
// ============================================================================
// Module     : tb_sad_abs_diff_accum
// Purpose    : Self-checking bench for sad_abs_diff_accum; block sums are
//              predicted by summing |a-b| over the pixel arrays it drives.
// Revision   : 1.0 - initial release
// ============================================================================
module tb_sad_abs_diff_accum;

  localparam int PIX_W = 8;
  localparam int BLK_N = 16;
  localparam int SAD_W = 12;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             valid = 1'b0;
  logic             sad_ready = 1'b0;
  logic [PIX_W-1:0] a = '0;
  logic [PIX_W-1:0] b = '0;
  logic             ready;
  logic             sad_valid;
  logic [SAD_W-1:0] sad;

  int vectors = 0;
  int miscompares = 0;
  int pa[BLK_N];
  int pb[BLK_N];

  always #5 clk = ~clk;

  sad_abs_diff_accum #(
    .PIX_W (PIX_W),
    .BLK_N (BLK_N),
    .SAD_W (SAD_W)
  ) dut (
    .i_clk       (clk),
    .i_rst       (rst),
    .i_valid     (valid),
    .i_a         (a),
    .i_b         (b),
    .o_ready     (ready),
    .o_sad       (sad),
    .o_sad_valid (sad_valid),
    .i_sad_ready (sad_ready)
  );

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Reference: SAD is the plain sum of absolute differences of the first n pairs.
  function automatic int ref_sad(input int n);
    int s = 0;
    for (int i = 0; i < n; i++) s += (pa[i] > pb[i]) ? pa[i] - pb[i] : pb[i] - pa[i];
    return s;
  endfunction

  // Present n pairs, idling 'gap' cycles before each; waits (bounded) for ready.
  task automatic feed_pairs(input int n, input int gap);
    int guard;
    for (int i = 0; i < n; i++) begin
      valid = 1'b0;
      repeat (gap) step();
      valid = 1'b1;
      a = PIX_W'(pa[i]);
      b = PIX_W'(pb[i]);
      guard = 0;
      while (!ready && guard < 50) begin
        step();
        guard++;
      end
      vectors++;
      if (!ready) begin
        miscompares++;
        $display("FAIL feed_timeout: ready=%0b required 1 at pair %0d", ready, i);
      end
      step();
    end
    valid = 1'b0;
  endtask

  // Wait for o_sad_valid; lat counts edges since the last accept.
  task automatic collect(output int lat, output logic ready_seen);
    lat = 0;
    ready_seen = ready;
    while (!sad_valid && lat < 40) begin
      step();
      lat++;
      if (ready) ready_seen = 1'b1;
    end
  endtask

  task automatic handshake();
    sad_ready = 1'b1;
    step();
    sad_ready = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid = 1'b1;
    a = 8'd99;
    b = 8'd1;
    repeat (3) step();
    vectors++;
    if (ready !== 1'b0 || sad_valid !== 1'b0 || sad !== '0) begin
      miscompares++;
      $display("FAIL reset_state: ready=%0b sad_valid=%0b sad=%0d required 0/0/0", ready, sad_valid, sad);
    end
    valid = 1'b0;
    rst = 1'b0;
    #1;
    vectors++;
    if (ready !== 1'b1) begin
      miscompares++;
      $display("FAIL reset_release_ready: ready=%0b required 1", ready);
    end
  endtask

  task automatic test_basic();
    int lat;
    logic rs;
    for (int i = 0; i < BLK_N; i++) begin pa[i] = 10; pb[i] = 3; end
    feed_pairs(BLK_N, 0);
    collect(lat, rs);
    vectors++;
    if (lat !== 2) begin
      miscompares++;
      $display("FAIL basic_latency: got %0d edges required 2", lat);
    end
    vectors++;
    if (rs !== 1'b0) begin
      miscompares++;
      $display("FAIL basic_ready_drain_hold: ready seen=%0b required 0", rs);
    end
    vectors++;
    if (sad !== SAD_W'(ref_sad(BLK_N)) || sad !== SAD_W'(112)) begin
      miscompares++;
      $display("FAIL basic_sad: got %0d required %0d", sad, ref_sad(BLK_N));
    end
    handshake();
    vectors++;
    if (sad_valid !== 1'b0 || ready !== 1'b1) begin
      miscompares++;
      $display("FAIL basic_handshake: sad_valid=%0b ready=%0b required 0/1", sad_valid, ready);
    end
  endtask

  task automatic test_sign();
    int lat;
    logic rs;
    int want[2] = '{112, 2400};
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < BLK_N; i++) begin
        if (k == 0) begin pa[i] = 3; pb[i] = 10; end
        else begin pa[i] = (i % 2 == 0) ? 200 : 50; pb[i] = (i % 2 == 0) ? 50 : 200; end
      end
      feed_pairs(BLK_N, 0);
      collect(lat, rs);
      vectors++;
      if (sad !== SAD_W'(ref_sad(BLK_N)) || sad !== SAD_W'(want[k]) || lat !== 2) begin
        miscompares++;
        $display("FAIL sign_block%0d: sad=%0d lat=%0d required %0d lat 2", k, sad, lat, want[k]);
      end
      handshake();
    end
  endtask

  task automatic test_extremes();
    int lat;
    logic rs;
    for (int k = 0; k < 2; k++) begin
      for (int i = 0; i < BLK_N; i++) begin pa[i] = (k == 0) ? 255 : 0; pb[i] = 255 - pa[i]; end
      feed_pairs(BLK_N, 0);
      collect(lat, rs);
      vectors++;
      if (sad !== SAD_W'(ref_sad(BLK_N)) || sad !== SAD_W'(4080)) begin
        miscompares++;
        $display("FAIL extreme_block%0d: sad=%0d required 4080", k, sad);
      end
      handshake();
    end
  endtask

  task automatic test_backpressure();
    int lat;
    logic rs;
    logic [SAD_W-1:0] held;
    int bad = 0;
    for (int i = 0; i < BLK_N; i++) begin pa[i] = $urandom_range(0, 255); pb[i] = $urandom_range(0, 255); end
    feed_pairs(BLK_N, 0);
    collect(lat, rs);
    held = sad;
    vectors++;
    if (sad !== SAD_W'(ref_sad(BLK_N))) begin
      miscompares++;
      $display("FAIL bp_sad: got %0d required %0d", sad, ref_sad(BLK_N));
    end
    valid = 1'b1;
    for (int c = 0; c < 5; c++) begin
      a = PIX_W'($urandom);
      b = PIX_W'($urandom);
      step();
      if (sad !== held || sad_valid !== 1'b1 || ready !== 1'b0) bad++;
    end
    valid = 1'b0;
    vectors++;
    if (bad !== 0) begin
      miscompares++;
      $display("FAIL bp_hold: %0d unstable cycles required 0", bad);
    end
    handshake();
    for (int i = 0; i < BLK_N; i++) begin pa[i] = $urandom_range(0, 255); pb[i] = pa[i]; end
    feed_pairs(BLK_N, 0);
    collect(lat, rs);
    vectors++;
    if (sad !== '0 || sad_valid !== 1'b1) begin
      miscompares++;
      $display("FAIL bp_restart: sad=%0d valid=%0b required 0/1", sad, sad_valid);
    end
    handshake();
  endtask

  task automatic test_gaps();
    int lat;
    logic rs;
    for (int i = 0; i < BLK_N; i++) begin pa[i] = 7; pb[i] = 2; end
    feed_pairs(BLK_N, 2);
    collect(lat, rs);
    vectors++;
    if (sad !== SAD_W'(ref_sad(BLK_N)) || sad !== SAD_W'(80) || lat !== 2) begin
      miscompares++;
      $display("FAIL gaps_sad: sad=%0d lat=%0d required 80 lat 2", sad, lat);
    end
    handshake();
  endtask

  task automatic test_mid_reset();
    int lat;
    logic rs;
    for (int i = 0; i < BLK_N; i++) begin pa[i] = $urandom_range(0, 255); pb[i] = $urandom_range(0, 255); end
    feed_pairs(7, 0);
    rst = 1'b1;
    #1;
    vectors++;
    if (ready !== 1'b0) begin
      miscompares++;
      $display("FAIL midrst_ready: ready=%0b required 0", ready);
    end
    step();
    rst = 1'b0;
    #1;
    vectors++;
    if (sad_valid !== 1'b0 || sad !== '0 || ready !== 1'b1) begin
      miscompares++;
      $display("FAIL midrst_state: sad_valid=%0b sad=%0d ready=%0b required 0/0/1", sad_valid, sad, ready);
    end
    for (int i = 0; i < BLK_N; i++) begin pa[i] = 1; pb[i] = 0; end
    feed_pairs(BLK_N, 0);
    collect(lat, rs);
    vectors++;
    if (sad !== SAD_W'(16) || sad !== SAD_W'(ref_sad(BLK_N)) || lat !== 2) begin
      miscompares++;
      $display("FAIL midrst_sad: sad=%0d lat=%0d required 16 lat 2", sad, lat);
    end
    handshake();
  endtask

  task automatic test_random();
    int lat;
    logic rs;
    for (int k = 0; k < 4; k++) begin
      for (int i = 0; i < BLK_N; i++) begin pa[i] = $urandom_range(0, 255); pb[i] = $urandom_range(0, 255); end
      feed_pairs(BLK_N, $urandom_range(0, 2));
      collect(lat, rs);
      vectors++;
      if (sad !== SAD_W'(ref_sad(BLK_N)) || lat !== 2 || rs !== 1'b0) begin
        miscompares++;
        $display("FAIL random_block%0d: sad=%0d lat=%0d ready_seen=%0b required %0d lat 2 ready 0",
                 k, sad, lat, rs, ref_sad(BLK_N));
      end
      handshake();
    end
  endtask

  initial begin
    test_reset();
    test_basic();
    test_sign();
    test_extremes();
    test_backpressure();
    test_gaps();
    test_mid_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
